pcm_uart_stream: RTL and testbench

Downstream consumer of the cic decimators' PCM output. On each en_pcm strobe it captures one 16-bit sample per channel as one frame and buffers frames in a small FIFO. It then streams each frame over an 8N1 UART as a sync byte, the channel bytes and an XOR checksum, for capture on a host.

---
 rtl/pcm_uart_stream_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 86 ++++++++
 rtl/pcm_uart_stream.sv | 161 ++++++++++++++++
 tb/tb_pcm_uart_stream.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_uart_stream_pkg.sv
// Shared constants for the PCM-to-UART streamer: sync byte, frame FSM and bit FSM encodings.
package pcm_uart_stream_pkg;

   // First byte of every frame, lets the host resynchronise after a lost byte.
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Frame-level FSM states.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Byte serializer states; BIT_IDLE is the line-idle state between symbols.
   localparam logic [1:0] BIT_IDLE  = 2'd0;
   localparam logic [1:0] BIT_START = 2'd1;
   localparam logic [1:0] BIT_DATA  = 2'd2;
   localparam logic [1:0] BIT_STOP  = 2'd3;

   // Increment an 8-bit counter that sticks at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each CLK_DIV clocks.
// ready is also raised in the last stop-bit cycle so consecutive bytes run gap-free.
module uart_tx_byte
   import pcm_uart_stream_pkg::*;
#(
   parameter int CLK_DIV = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);

   localparam int DW = $clog2(CLK_DIV);

   logic [1:0]    bit_state;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          bit_end;
   logic          accept;

   assign bit_end = (div_cnt == DW'(CLK_DIV - 1));
   assign ready   = (bit_state == BIT_IDLE) || ((bit_state == BIT_STOP) && bit_end);
   assign accept  = valid && ready;

   // Walk through the symbol one bit period at a time; the divider restarts on every accepted byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_state <= BIT_IDLE;
         div_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         tx        <= 1'b1;
      end else if (accept) begin
         bit_state <= BIT_START;
         div_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= data;
         tx        <= 1'b0;
      end else begin
         case (bit_state)
            BIT_IDLE: begin
               div_cnt <= '0;
               tx      <= 1'b1;
            end
            BIT_START: begin
               if (bit_end) begin
                  bit_state <= BIT_DATA;
                  div_cnt   <= '0;
                  tx        <= shift[0];
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            BIT_DATA: begin
               if (bit_end) begin
                  div_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_state <= BIT_STOP;
                     tx        <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            BIT_STOP: begin
               if (bit_end) begin
                  bit_state <= BIT_IDLE;
                  div_cnt   <= '0;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            default: bit_state <= BIT_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pcm_uart_stream.sv
// Captures one multi-channel PCM frame per en_pcm strobe into a small FIFO and streams
// each frame over UART as: sync byte, channel bytes (MSB first), XOR checksum.
module pcm_uart_stream
   import pcm_uart_stream_pkg::*;
#(
   parameter int CHANNELS = 3,
   parameter int DEPTH    = 4,
   parameter int CLK_DIV  = 104
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en_pcm,
   input  logic [16*CHANNELS-1:0]  pcm_in,
   output logic                    tx,
   output logic                    busy,
   output logic                    overrun,
   output logic [7:0]              drop_count
);

   localparam int FW  = 16 * CHANNELS;
   localparam int NCB = 2 * CHANNELS;
   localparam int IW  = $clog2(NCB + 2);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;

   logic [FW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [IW-1:0] byte_idx;
   logic [FW-1:0] frame_reg;
   logic [7:0]    checksum;
   logic [7:0]    chan_byte;

   logic          pop;
   logic          push;
   logic          drop;
   logic          ser_valid;
   logic          ser_ready;
   logic [7:0]    ser_data;

   assign pop  = (state == ST_IDLE) && (count != '0);
   assign push = en_pcm && ((count != CW'(DEPTH)) || pop);
   assign drop = en_pcm && !push;

   // Pick the channel byte addressed by byte_idx: even index is a channel's MSB, odd its LSB.
   always_comb begin
      chan_byte = '0;
      for (int k = 0; k < NCB; k++) begin
         if (byte_idx == IW'(k)) begin
            chan_byte = frame_reg[16*(k/2) + 8*(1 - (k%2)) +: 8];
         end
      end
   end

   // The sync byte is offered in the pop cycle itself so the start bit follows the pop directly;
   // in SEND the channel bytes and then the checksum follow, and the last index just waits.
   always_comb begin
      ser_valid = 1'b0;
      ser_data  = SYNC_BYTE;
      case (state)
         ST_IDLE: ser_valid = pop;
         ST_SEND: begin
            if (byte_idx <= IW'(NCB)) begin
               ser_valid = 1'b1;
               ser_data  = (byte_idx == IW'(NCB)) ? checksum : chan_byte;
            end
         end
         default: ser_valid = 1'b0;
      endcase
   end

   // Next frame state and FIFO occupancy, shared by the registers and the busy flag.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (pop) state_next = ST_SEND;
         ST_SEND: if ((byte_idx == IW'(NCB + 1)) && ser_ready) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Frame FSM: load the frame on pop, then step through the bytes and fold channel bytes into the checksum.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         byte_idx  <= '0;
         frame_reg <= '0;
         checksum  <= '0;
      end else begin
         state <= state_next;
         if (pop) begin
            frame_reg <= mem[rd_ptr];
            checksum  <= '0;
            byte_idx  <= '0;
         end else if ((state == ST_SEND) && ser_valid && ser_ready) begin
            byte_idx <= byte_idx + IW'(1);
            if (byte_idx != IW'(NCB)) begin
               checksum <= checksum ^ chan_byte;
            end
         end
      end
   end

   // FIFO storage has no reset; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= pcm_in;
      end
   end

   // FIFO pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
      end
   end

   // Status flags: sticky overrun, saturating drop counter, and busy tracking the upcoming state.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun    <= 1'b0;
         drop_count <= '0;
         busy       <= 1'b0;
      end else begin
         if (drop) begin
            overrun    <= 1'b1;
            drop_count <= sat_inc8(drop_count);
         end
         busy <= (state_next != ST_IDLE) || (count_next != '0);
      end
   end

   uart_tx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clk   (clk),
      .reset (reset),
      .data  (ser_data),
      .valid (ser_valid),
      .ready (ser_ready),
      .tx    (tx)
   );

endmodule

// File: tb/tb_pcm_uart_stream.sv
// Bench for pcm_uart_stream: a frame-level line model checked every cycle, a UART decoder
// for readable byte checks, and directed scenarios with hand-computed expectations.
module tb_pcm_uart_stream;

   localparam int CH        = 3;
   localparam int DEPTH     = 4;
   localparam int DIV       = 4;
   localparam int NB        = 2 * CH + 2;
   localparam int FW        = 16 * CH;
   localparam int FRAME_CYC = NB * 10 * DIV;

   logic          clk = 1'b0;
   logic          reset;
   logic          en_pcm;
   logic [FW-1:0] pcm_in;
   logic          tx;
   logic          busy;
   logic          overrun;
   logic [7:0]    drop_count;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   pcm_uart_stream #(
      .CHANNELS (CH),
      .DEPTH    (DEPTH),
      .CLK_DIV  (DIV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en_pcm     (en_pcm),
      .pcm_in     (pcm_in),
      .tx         (tx),
      .busy       (busy),
      .overrun    (overrun),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   // Byte list of a frame: byte i lives at bits [8i+7:8i].
   function automatic logic [8*NB-1:0] frame_bytes(input logic [FW-1:0] v);
      logic [8*NB-1:0] r;
      logic [7:0]      x;
      logic [7:0]      b;
      r      = '0;
      x      = 8'h00;
      r[7:0] = 8'hA5;
      for (int k = 0; k < 2 * CH; k++) begin
         b = ((k % 2) == 0) ? v[16*(k/2)+8 +: 8] : v[16*(k/2) +: 8];
         r[8*(k+1) +: 8] = b;
         x = x ^ b;
      end
      r[8*(NB-1) +: 8] = x;
      return r;
   endfunction

   // Distinct test vector per index.
   function automatic logic [FW-1:0] mk_vec(input int i);
      logic [FW-1:0] v;
      for (int k = 0; k < CH; k++) begin
         v[16*k +: 16] = 16'(i * 16'h1111 + k * 16'h0F01 + 16'h0123);
      end
      return v;
   endfunction

   // Line-level model: FIFO of frames, expected per-cycle tx waveform, non-idle cycle budget.
   logic [FW-1:0] m_q[$];
   logic          m_line[$];
   int            m_left  = 0;
   logic          m_ovr   = 1'b0;
   logic [7:0]    m_drops = 8'd0;
   logic          exp_tx  = 1'b1;
   logic          exp_busy = 1'b0;

   always @(posedge clk) begin : model
      logic [8*NB-1:0] fb;
      logic [7:0]      bt;
      logic            was_full;
      logic            do_pop;
      if (reset) begin
         m_q.delete();
         m_line.delete();
         m_left  = 0;
         m_ovr   = 1'b0;
         m_drops = 8'd0;
      end else begin
         was_full = (m_q.size() >= DEPTH);
         do_pop   = (m_left == 0) && (m_q.size() != 0);
         if (do_pop) begin
            fb = frame_bytes(m_q.pop_front());
            for (int i = 0; i < NB; i++) begin
               bt = fb[8*i +: 8];
               for (int c = 0; c < DIV; c++) m_line.push_back(1'b0);
               for (int j = 0; j < 8; j++)
                  for (int c = 0; c < DIV; c++) m_line.push_back(bt[j]);
               for (int c = 0; c < DIV; c++) m_line.push_back(1'b1);
            end
            m_left = FRAME_CYC + 1;
         end else if (m_left > 0) begin
            m_left = m_left - 1;
         end
         if (en_pcm) begin
            if (!was_full || do_pop) begin
               m_q.push_back(pcm_in);
            end else begin
               m_ovr = 1'b1;
               if (m_drops != 8'hFF) m_drops = m_drops + 8'd1;
            end
         end
      end
      exp_tx   = (m_line.size() != 0) ? m_line.pop_front() : 1'b1;
      exp_busy = (m_left != 0) || (m_q.size() != 0);
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (cmp_en) begin
            checks++;
            if ({tx, busy, overrun, drop_count} !== {exp_tx, exp_busy, m_ovr, m_drops}) begin
               errors++;
               $display("[TB] FAIL cycle_model @%0t: got tx=%b busy=%b overrun=%b drops=%0d, required tx=%b busy=%b overrun=%b drops=%0d",
                        $time, tx, busy, overrun, drop_count, exp_tx, exp_busy, m_ovr, m_drops);
            end
         end
      end
   end

   // UART receiver sampling each bit mid-period; abandons the byte on reset.
   logic [7:0] rx_q[$];
   initial begin : decoder
      bit         dact;
      int         dcnt;
      logic [7:0] dsh;
      dact = 1'b0;
      dcnt = 0;
      dsh  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset === 1'b1) begin
            dact = 1'b0;
         end else if (!dact) begin
            if (tx === 1'b0) begin
               dact = 1'b1;
               dcnt = 0;
            end
         end else begin
            dcnt++;
            for (int i = 0; i < 8; i++)
               if (dcnt == DIV * (i + 1) + DIV / 2) dsh[i] = tx;
            if (dcnt == DIV * 9 + DIV / 2) begin
               rx_q.push_back(dsh);
               dact = 1'b0;
            end
         end
      end
   end

   logic [FW-1:0] exp_vec[$];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic apply_stimulus(input logic [FW-1:0] v);
      @(negedge clk);
      en_pcm = 1'b1;
      pcm_in = v;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < max_cycles) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_rx(input string name);
      logic [8*NB-1:0] fb;
      check_output({name, "_len"}, rx_q.size(), exp_vec.size() * NB);
      for (int f = 0; f < exp_vec.size(); f++) begin
         fb = frame_bytes(exp_vec[f]);
         for (int b = 0; b < NB; b++)
            if (f * NB + b < rx_q.size())
               check_output(name, {24'd0, rx_q[f*NB+b]}, {24'd0, fb[8*b +: 8]});
      end
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : stimulus
      logic [7:0] gold [8];
      gold = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBF};
      reset  = 1'b1;
      en_pcm = 1'b0;
      pcm_in = '0;

      // Reset held three cycles, then quiet line for 50 cycles.
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      reset  = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check_output("reset_tx", {31'd0, tx}, 32'd1);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      check_output("reset_overrun", {31'd0, overrun}, 32'd0);
      check_output("reset_drops", {24'd0, drop_count}, 32'd0);

      // Single frame: start-bit latency, 320-cycle frame, busy drops the cycle after DONE.
      $display("[TB] single frame");
      rx_q.delete();
      apply_stimulus({16'h00FF, 16'hABCD, 16'h1234});
      @(posedge clk);
      #1;
      en_pcm = 1'b0;
      check_output("start_not_early", {31'd0, tx}, 32'd1);
      @(posedge clk);
      #1;
      check_output("start_bit_latency", {31'd0, tx}, 32'd0);
      repeat (FRAME_CYC) @(posedge clk);
      #1;
      check_output("busy_in_done", {31'd0, busy}, 32'd1);
      check_output("tx_idle_after_frame", {31'd0, tx}, 32'd1);
      @(posedge clk);
      #1;
      check_output("busy_drop", {31'd0, busy}, 32'd0);
      check_output("frame_len", rx_q.size(), 32'd8);
      for (int i = 0; i < 8; i++)
         if (i < rx_q.size()) check_output("frame_literal", {24'd0, rx_q[i]}, {24'd0, gold[i]});

      // Overflow: six strobes two cycles apart, one dropped.
      $display("[TB] overflow");
      rx_q.delete();
      exp_vec.delete();
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(mk_vec(i));
         if (i < 5) exp_vec.push_back(mk_vec(i));
         @(negedge clk);
         en_pcm = 1'b0;
      end
      wait_idle(4000);
      check_output("overflow_drops", {24'd0, drop_count}, 32'd1);
      check_output("overflow_flag", {31'd0, overrun}, 32'd1);
      check_rx("overflow_bytes");

      // Saturation: 305 back-to-back strobes, only the first five fit.
      $display("[TB] saturation");
      rx_q.delete();
      exp_vec.delete();
      for (int i = 0; i < 305; i++) begin
         apply_stimulus(mk_vec(10 + i));
         if (i < 5) exp_vec.push_back(mk_vec(10 + i));
      end
      @(negedge clk);
      en_pcm = 1'b0;
      wait_idle(4000);
      check_output("sat_drops", {24'd0, drop_count}, 32'd255);
      check_output("sat_flag", {31'd0, overrun}, 32'd1);
      check_rx("sat_bytes");

      // Reset during the third byte's data bits, then a clean frame.
      $display("[TB] reset mid-frame");
      apply_stimulus(mk_vec(40));
      @(negedge clk);
      en_pcm = 1'b0;
      repeat (91) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_output("midreset_tx", {31'd0, tx}, 32'd1);
      check_output("midreset_busy", {31'd0, busy}, 32'd0);
      check_output("midreset_overrun", {31'd0, overrun}, 32'd0);
      check_output("midreset_drops", {24'd0, drop_count}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rx_q.delete();
      exp_vec.delete();
      apply_stimulus(mk_vec(41));
      exp_vec.push_back(mk_vec(41));
      @(negedge clk);
      en_pcm = 1'b0;
      wait_idle(1000);
      check_rx("post_reset_bytes");

      // Push in the pop cycle with the FIFO full: accepted, next strobe then drops.
      $display("[TB] push and pop in one cycle");
      rx_q.delete();
      exp_vec.delete();
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(mk_vec(20 + i));
         exp_vec.push_back(mk_vec(20 + i));
      end
      @(negedge clk);
      en_pcm = 1'b0;
      repeat (318) @(negedge clk);
      en_pcm = 1'b1;
      pcm_in = mk_vec(30);
      exp_vec.push_back(mk_vec(30));
      @(negedge clk);
      check_output("popcycle_push_accepted", {24'd0, drop_count}, 32'd0);
      pcm_in = mk_vec(31);
      @(negedge clk);
      en_pcm = 1'b0;
      @(posedge clk);
      #1;
      check_output("fifo_still_full", {24'd0, drop_count}, 32'd1);
      wait_idle(5000);
      check_rx("popcycle_bytes");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
